// File: rtl/chiplet_pkg.sv
// -----------------------------------------------------------------------------
// chiplet_pkg
//   Shared types for the chiplet link layer.
//   - PKG_FLIT_W    : width of one flit on the link.
//   - flit_t        : one flit as a packed struct.
//   - credit_token  : builds a credit-return token. The low bits carry the VC
//                     number and every other bit is zero.
//   - sched_state_e : state encoding of the link transmit scheduler.
// -----------------------------------------------------------------------------
package chiplet_pkg;

   localparam int PKG_FLIT_W  = 32;
   // Field width reserved for the VC number inside a credit token.
   localparam int TOKEN_VC_W  = 8;

   typedef struct packed {
      logic [PKG_FLIT_W-1:0] payload;
   } flit_t;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      SEND      = 2'd1,
      WAIT_DONE = 2'd2
   } sched_state_e;

   // A credit token is the VC number zero-extended to a full flit.
   function automatic flit_t credit_token(input logic [TOKEN_VC_W-1:0] vc);
      flit_t tok;
      tok = '0;
      tok.payload[TOKEN_VC_W-1:0] = vc;
      return tok;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Round-robin arbiter. The grant is combinational. A registered pointer holds
//   the last index served, and the search starts at the index after it. The
//   pointer moves only when advance_i is asserted together with a valid grant.
//   The link scheduler uses it to pick token VCs. The switch allocator can
//   reuse it.
//
// Ports
//   clk           in   clock
//   n_rst         in   asynchronous active-low reset
//   req_i         in   N request lines
//   advance_i     in   the current grant was taken; update the pointer
//   grant_o       out  one-hot grant
//   grant_idx_o   out  index of the granted requester
//   grant_valid_o out  at least one request is present
// -----------------------------------------------------------------------------
module rr_arbiter #(
   parameter int N = 2,
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic [N-1:0]     req_i,
   input  logic             advance_i,
   output logic [N-1:0]     grant_o,
   output logic [IDX_W-1:0] grant_idx_o,
   output logic             grant_valid_o
);

   logic [IDX_W-1:0] last_q;
   logic [IDX_W-1:0] last_d;

   // Start the scan one index past the last winner and take the first request.
   always_comb begin
      int cand;
      cand          = 0;
      grant_o       = '0;
      grant_idx_o   = '0;
      grant_valid_o = 1'b0;
      for (int i = 0; i < N; i++) begin
         cand = (int'(last_q) + i + 1) % N;
         if (!grant_valid_o && req_i[cand]) begin
            grant_valid_o = 1'b1;
            grant_o[cand] = 1'b1;
            grant_idx_o   = IDX_W'(cand);
         end
      end
   end

   always_comb begin
      last_d = last_q;
      if (advance_i && grant_valid_o) begin
         last_d = grant_idx_o;
      end
   end

   // The pointer resets to the top index, so index 0 is served first.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         last_q <= IDX_W'(N - 1);
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/link_tx_scheduler.sv
// -----------------------------------------------------------------------------
// link_tx_scheduler
//   Transmit controller for one link, between a switch output port and the
//   endnode transmitter. It keeps a downstream credit counter per VC and holds
//   data flits back until credit is available. Credit-return tokens for
//   upstream are counted per VC and sent ahead of data. The endnode handshake
//   allows exactly one flit or token in flight. All outputs are registered.
//
// Ports
//   clk            in   system clock
//   n_rst          in   asynchronous active-low reset
//   flit_valid     in   switch has a flit ready
//   flit_in        in   flit data; held by the switch until flit_ack
//   flit_vc        in   VC of flit_in
//   flit_ack       out  one-cycle pulse: flit accepted
//   credit_return  in   per-VC pulse: local buffer freed a slot
//   credit_rx      in   per-VC pulse: credit received from downstream
//   tx_start       out  one-cycle pulse: endnode starts sending tx_data
//   tx_data        out  flit or token, stable until tx_done
//   tx_is_credit   out  tx_data is a credit token
//   tx_done        in   endnode finished the current transfer
//   credits        out  packed downstream credit counters, VC0 in the low bits
//   err            out  sticky counter-overflow flag
// -----------------------------------------------------------------------------
module link_tx_scheduler
   import chiplet_pkg::*;
#(
   parameter int NUM_VCS     = 2,
   parameter int BUFFER_SIZE = 8,
   // Must match PKG_FLIT_W so that flit_t and tx_data line up.
   parameter int FLIT_W      = 32,
   localparam int VC_W       = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1,
   localparam int CNT_W      = $clog2(BUFFER_SIZE + 1)
) (
   input  logic                     clk,
   input  logic                     n_rst,
   input  logic                     flit_valid,
   input  logic [FLIT_W-1:0]        flit_in,
   input  logic [VC_W-1:0]          flit_vc,
   output logic                     flit_ack,
   input  logic [NUM_VCS-1:0]       credit_return,
   input  logic [NUM_VCS-1:0]       credit_rx,
   output logic                     tx_start,
   output logic [FLIT_W-1:0]        tx_data,
   output logic                     tx_is_credit,
   input  logic                     tx_done,
   output logic [NUM_VCS*CNT_W-1:0] credits,
   output logic                     err
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BUFFER_SIZE);

   sched_state_e      state_q, state_d;
   logic              flit_ack_q, flit_ack_d;
   logic              tx_start_q, tx_start_d;
   logic              tx_is_credit_q, tx_is_credit_d;
   logic [FLIT_W-1:0] tx_data_q, tx_data_d;
   logic              err_q, err_d;

   logic [NUM_VCS-1:0] vc_hit;      // flit_vc decoded to one-hot
   logic [NUM_VCS-1:0] credit_nz;   // credit counter is non-zero
   logic [NUM_VCS-1:0] pend_nz;     // tokens waiting on this VC
   logic [NUM_VCS-1:0] consume;     // data flit takes a credit this cycle
   logic [NUM_VCS-1:0] tok_take;    // token latched for this VC this cycle
   logic [NUM_VCS-1:0] credit_ovf;
   logic [NUM_VCS-1:0] pend_ovf;

   logic               take_tok;
   logic               take_flit;
   logic               flit_has_credit;

   logic [NUM_VCS-1:0] tok_grant;
   logic [VC_W-1:0]    tok_idx;
   logic               tok_valid;
   flit_t              tok_flit;

   // ---------------------------------------------------------------------------
   // Per-VC counters
   // ---------------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < NUM_VCS; gi++) begin : g_vc
         logic [CNT_W-1:0] credit_q, credit_d;
         logic [CNT_W-1:0] pend_q, pend_d;

         assign vc_hit[gi]    = (flit_vc == VC_W'(gi));
         assign credit_nz[gi] = (credit_q != '0);
         assign pend_nz[gi]   = (pend_q != '0);

         // A counter overflows only when the increment is not cancelled by a
         // decrement in the same cycle.
         assign credit_ovf[gi] = credit_rx[gi] && !consume[gi] && (credit_q == CNT_MAX);
         assign pend_ovf[gi]   = credit_return[gi] && !tok_take[gi] && (pend_q == CNT_MAX);

         always_comb begin
            credit_d = credit_q;
            if (credit_rx[gi] && !consume[gi]) begin
               if (credit_q != CNT_MAX) begin
                  credit_d = credit_q + CNT_W'(1);
               end
            end else if (!credit_rx[gi] && consume[gi]) begin
               credit_d = credit_q - CNT_W'(1);
            end
         end

         always_comb begin
            pend_d = pend_q;
            if (credit_return[gi] && !tok_take[gi]) begin
               if (pend_q != CNT_MAX) begin
                  pend_d = pend_q + CNT_W'(1);
               end
            end else if (!credit_return[gi] && tok_take[gi]) begin
               pend_d = pend_q - CNT_W'(1);
            end
         end

         always_ff @(posedge clk or negedge n_rst) begin
            if (!n_rst) begin
               credit_q <= CNT_MAX;
               pend_q   <= '0;
            end else begin
               credit_q <= credit_d;
               pend_q   <= pend_d;
            end
         end

         assign credits[gi*CNT_W +: CNT_W] = credit_q;
      end
   endgenerate

   assign flit_has_credit = |(vc_hit & credit_nz);

   // ---------------------------------------------------------------------------
   // Token VC selection
   // ---------------------------------------------------------------------------
   rr_arbiter #(
      .N (NUM_VCS)
   ) u_tok_arb (
      .clk           (clk),
      .n_rst         (n_rst),
      .req_i         (pend_nz),
      .advance_i     (take_tok),
      .grant_o       (tok_grant),
      .grant_idx_o   (tok_idx),
      .grant_valid_o (tok_valid)
   );

   assign tok_flit = credit_token(TOKEN_VC_W'(tok_idx));
   assign tok_take = take_tok  ? tok_grant : '0;
   assign consume  = take_flit ? vc_hit    : '0;

   // ---------------------------------------------------------------------------
   // Transfer FSM. The strobes are computed one cycle early so that tx_start
   // and flit_ack come out of flops during SEND.
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d        = state_q;
      flit_ack_d     = 1'b0;
      tx_start_d     = 1'b0;
      tx_data_d      = tx_data_q;
      tx_is_credit_d = tx_is_credit_q;
      take_tok       = 1'b0;
      take_flit      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (tok_valid) begin
               // Tokens win over data so that upstream never waits behind
               // a credit-starved VC.
               take_tok       = 1'b1;
               tx_data_d      = FLIT_W'(tok_flit);
               tx_is_credit_d = 1'b1;
               tx_start_d     = 1'b1;
               state_d        = SEND;
            end else if (flit_valid && flit_has_credit) begin
               take_flit      = 1'b1;
               tx_data_d      = flit_in;
               tx_is_credit_d = 1'b0;
               tx_start_d     = 1'b1;
               flit_ack_d     = 1'b1;
               state_d        = SEND;
            end
            // A flit without credit stalls the port until credit arrives.
         end
         SEND: begin
            state_d = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (tx_done) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign err_d = err_q | (|credit_ovf) | (|pend_ovf);

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q        <= IDLE;
         flit_ack_q     <= 1'b0;
         tx_start_q     <= 1'b0;
         tx_data_q      <= '0;
         tx_is_credit_q <= 1'b0;
         err_q          <= 1'b0;
      end else begin
         state_q        <= state_d;
         flit_ack_q     <= flit_ack_d;
         tx_start_q     <= tx_start_d;
         tx_data_q      <= tx_data_d;
         tx_is_credit_q <= tx_is_credit_d;
         err_q          <= err_d;
      end
   end

   assign flit_ack     = flit_ack_q;
   assign tx_start     = tx_start_q;
   assign tx_data      = tx_data_q;
   assign tx_is_credit = tx_is_credit_q;
   assign err          = err_q;

endmodule

// File: tb/tb_link_tx_scheduler.sv
// -----------------------------------------------------------------------------
// tb_link_tx_scheduler
//   Scoreboard bench. Each flit or credit token is pushed as an expectation
//   when it is driven. The endnode model pops the expectation on every
//   tx_start, compares it with tx_data and tx_is_credit, and returns tx_done
//   a fixed number of cycles later.
// -----------------------------------------------------------------------------
module tb_link_tx_scheduler;

   localparam int NUM_VCS       = 2;
   localparam int BUFFER_SIZE   = 8;
   localparam int FLIT_W        = 32;
   localparam int VC_W          = 1;
   localparam int CNT_W         = 4;
   localparam int ENDNODE_DELAY = 4;

   logic                     clk = 1'b0;
   logic                     n_rst;
   logic                     flit_valid;
   logic [FLIT_W-1:0]        flit_in;
   logic [VC_W-1:0]          flit_vc;
   logic                     flit_ack;
   logic [NUM_VCS-1:0]       credit_return;
   logic [NUM_VCS-1:0]       credit_rx;
   logic                     tx_start;
   logic [FLIT_W-1:0]        tx_data;
   logic                     tx_is_credit;
   logic                     tx_done;
   logic [NUM_VCS*CNT_W-1:0] credits;
   logic                     err;

   always #5 clk = ~clk;

   link_tx_scheduler #(
      .NUM_VCS     (NUM_VCS),
      .BUFFER_SIZE (BUFFER_SIZE),
      .FLIT_W      (FLIT_W)
   ) dut (
      .clk           (clk),
      .n_rst         (n_rst),
      .flit_valid    (flit_valid),
      .flit_in       (flit_in),
      .flit_vc       (flit_vc),
      .flit_ack      (flit_ack),
      .credit_return (credit_return),
      .credit_rx     (credit_rx),
      .tx_start      (tx_start),
      .tx_data       (tx_data),
      .tx_is_credit  (tx_is_credit),
      .tx_done       (tx_done),
      .credits       (credits),
      .err           (err)
   );

   typedef struct packed {
      logic [FLIT_W-1:0] data;
      logic              is_credit;
   } exp_t;

   exp_t exp_q[$];
   int   errors    = 0;
   int   checks    = 0;
   int   acks_seen = 0;
   int   acks_exp  = 0;
   int   done_cnt  = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Endnode model and scoreboard consumer.
   initial begin : endnode
      exp_t e;
      tx_done = 1'b0;
      forever begin
         @(negedge clk);
         if (flit_ack) begin
            acks_seen++;
            check_eq("ack_has_start", {63'd0, tx_start}, 64'd1);
         end
         if (!n_rst) begin
            done_cnt = 0;
            tx_done  = 1'b0;
         end else if (tx_start) begin
            $display("TX data=%08h is_credit=%0b ack=%0b credits=%02h", tx_data, tx_is_credit, flit_ack, credits);
            check_eq("tx_expected", {63'd0, exp_q.size() != 0}, 64'd1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check_eq("tx_data", {32'd0, tx_data}, {32'd0, e.data});
               check_eq("tx_is_credit", {63'd0, tx_is_credit}, {63'd0, e.is_credit});
               check_eq("ack_matches_kind", {63'd0, flit_ack}, {63'd0, !e.is_credit});
            end
            done_cnt = ENDNODE_DELAY;
            tx_done  = 1'b0;
         end else if (done_cnt > 0) begin
            done_cnt--;
            tx_done = (done_cnt == 0);
         end else begin
            tx_done = 1'b0;
         end
      end
   end

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push_exp(input logic [FLIT_W-1:0] data, input logic is_credit);
      exp_t e;
      e.data      = data;
      e.is_credit = is_credit;
      exp_q.push_back(e);
   endtask

   task automatic present_flit(input logic [VC_W-1:0] vc, input logic [FLIT_W-1:0] data);
      flit_valid = 1'b1;
      flit_vc    = vc;
      flit_in    = data;
      push_exp(data, 1'b0);
      acks_exp++;
   endtask

   task automatic release_flit();
      flit_valid = 1'b0;
      flit_in    = '0;
      flit_vc    = '0;
   endtask

   // Returns the number of negedges until flit_ack is seen, or -1 on timeout.
   task automatic wait_ack(input int max_wait, output int lat);
      lat = -1;
      for (int i = 1; i <= max_wait; i++) begin
         @(negedge clk);
         if (flit_ack) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic send_flit(input logic [VC_W-1:0] vc, input logic [FLIT_W-1:0] data, output int lat);
      present_flit(vc, data);
      wait_ack(40, lat);
      release_flit();
      check_eq("ack_within_bound", {63'd0, lat > 0}, 64'd1);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int lat;
      n_rst         = 1'b0;
      flit_valid    = 1'b0;
      flit_in       = '0;
      flit_vc       = '0;
      credit_return = '0;
      credit_rx     = '0;
      wait_cycles(3);

      // Reset state
      check_eq("rst_credits", {56'd0, credits}, 64'h88);
      check_eq("rst_err", {63'd0, err}, 64'd0);
      check_eq("rst_tx_start", {63'd0, tx_start}, 64'd0);
      check_eq("rst_flit_ack", {63'd0, flit_ack}, 64'd0);
      check_eq("rst_tx_data", {32'd0, tx_data}, 64'd0);
      check_eq("rst_tx_is_credit", {63'd0, tx_is_credit}, 64'd0);
      n_rst = 1'b1;
      wait_cycles(2);

      // Single VC0 flit: ack and tx_start one cycle after it is presented
      send_flit(1'b0, 32'hDEADBEEF, lat);
      check_eq("t1_latency", 64'(lat), 64'd1);
      check_eq("t1_tx_start", {63'd0, tx_start}, 64'd1);
      check_eq("t1_credits0", {60'd0, credits[3:0]}, 64'd7);
      wait_cycles(6);

      // Drain all VC1 credits, then a ninth flit stalls until credit_rx
      for (int k = 0; k < 8; k++) begin
         send_flit(1'b1, 32'h1000_0000 + 32'(k), lat);
         wait_cycles(6);
      end
      check_eq("t2_credits1_empty", {60'd0, credits[7:4]}, 64'd0);
      present_flit(1'b1, 32'h1000_0008);
      wait_ack(10, lat);
      check_eq("t2_stall_no_ack", {63'd0, lat < 0}, 64'd1);
      credit_rx = 2'b10;
      @(negedge clk);
      credit_rx = 2'b00;
      wait_ack(5, lat);
      release_flit();
      check_eq("t2_ack_after_rx", 64'(lat), 64'd1);
      check_eq("t2_credits1_after", {60'd0, credits[7:4]}, 64'd0);
      wait_cycles(6);

      // Tokens on both VCs overtake a waiting VC0 data flit
      send_flit(1'b0, 32'hA000_0001, lat);
      credit_return = 2'b11;
      push_exp(32'd0, 1'b1);
      push_exp(32'd1, 1'b1);
      @(negedge clk);
      credit_return = 2'b00;
      send_flit(1'b0, 32'hB000_0002, lat);
      check_eq("t3_data_after_tokens", {63'd0, lat > 10}, 64'd1);
      wait_cycles(8);
      check_eq("t3_credits0", {60'd0, credits[3:0]}, 64'd5);
      check_eq("t3_no_token_left", 64'(exp_q.size()), 64'd0);

      // Credit consumed and returned on VC0 in the same cycle
      present_flit(1'b0, 32'hC000_0003);
      credit_rx = 2'b01;
      @(negedge clk);
      credit_rx = 2'b00;
      check_eq("t5_ack", {63'd0, flit_ack}, 64'd1);
      release_flit();
      check_eq("t5_credits0_same", {60'd0, credits[3:0]}, 64'd5);
      wait_cycles(6);

      // Refill both VCs together, then overflow VC0
      credit_rx = 2'b11;
      wait_cycles(3);
      credit_rx = 2'b00;
      @(negedge clk);
      check_eq("t4_credits_full", {56'd0, credits}, 64'h38);
      check_eq("t4_err_before", {63'd0, err}, 64'd0);
      credit_rx = 2'b01;
      @(negedge clk);
      credit_rx = 2'b00;
      check_eq("t4_credits0_sat", {60'd0, credits[3:0]}, 64'd8);
      check_eq("t4_err_set", {63'd0, err}, 64'd1);
      wait_cycles(5);
      check_eq("t4_err_sticky", {63'd0, err}, 64'd1);

      // Reset while WAIT_DONE is in progress
      send_flit(1'b1, 32'hD000_0004, lat);
      @(negedge clk);
      n_rst = 1'b0;
      #1;
      check_eq("t6_rst_tx_start", {63'd0, tx_start}, 64'd0);
      check_eq("t6_rst_credits", {56'd0, credits}, 64'h88);
      check_eq("t6_rst_err", {63'd0, err}, 64'd0);
      check_eq("t6_rst_tx_data", {32'd0, tx_data}, 64'd0);
      @(negedge clk);
      n_rst = 1'b1;
      wait_cycles(10);
      send_flit(1'b0, 32'hE000_0005, lat);
      check_eq("t6_idle_latency", 64'(lat), 64'd1);
      check_eq("t6_credits0", {60'd0, credits[3:0]}, 64'd7);
      wait_cycles(10);

      check_eq("acks_total", 64'(acks_seen), 64'(acks_exp));
      check_eq("scoreboard_empty", 64'(exp_q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
